// File: rtl/seq_chunk_adder_if.sv
// Handshake and operand/result bundle for the chunked adder/subtractor.
// The master side issues operations; the slave side is the arithmetic unit.
interface seq_chunk_adder_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             sub;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] S;
   logic             Cout;
   logic             ovf;

   modport master (
      output start, A, B, Cin, sub,
      input  busy, done, S, Cout, ovf
   );

   modport slave (
      input  start, A, B, Cin, sub,
      output busy, done, S, Cout, ovf
   );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, LSB chunk
// first, rippling the carry between cycles through a carry register.
// Results (S/Cout/ovf) only change on the edge that completes an operation.
module seq_chunk_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input logic             clk,
   input logic             rst_n,
   seq_chunk_adder_if.slave bus
);
   localparam int NCH  = WIDTH / CHUNK;
   localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

   generate
      if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
         $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t            state_reg;
   state_t            state_next;
   logic              busy_flag;
   logic              done_flag;

   logic [WIDTH-1:0]  a_reg;
   logic [WIDTH-1:0]  b_reg;       // already inverted for subtract
   logic              carry_reg;
   logic [IDXW-1:0]   idx_reg;
   logic [WIDTH-1:0]  psum_reg;
   logic [WIDTH-1:0]  s_reg;
   logic              cout_reg;
   logic              ovf_reg;

   logic [CHUNK-1:0]  a_chunk [NCH];
   logic [CHUNK-1:0]  b_chunk [NCH];
   logic [CHUNK:0]    chunk_sum;
   logic [WIDTH-1:0]  psum_merged;
   logic              last_chunk;
   logic              accept;

   // Slice the captured operands into per-chunk views and splice the chunk
   // being computed this cycle into the partial sum.
   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_chunk
         assign a_chunk[gi] = a_reg[gi*CHUNK +: CHUNK];
         assign b_chunk[gi] = b_reg[gi*CHUNK +: CHUNK];
         assign psum_merged[gi*CHUNK +: CHUNK] =
            (idx_reg == IDXW'(gi)) ? chunk_sum[CHUNK-1:0]
                                   : psum_reg[gi*CHUNK +: CHUNK];
      end
   endgenerate

   assign chunk_sum  = {1'b0, a_chunk[idx_reg]} + {1'b0, b_chunk[idx_reg]}
                     + {{CHUNK{1'b0}}, carry_reg};
   assign last_chunk = (idx_reg == IDXW'(NCH - 1));
   // New work is taken whenever the unit is not busy (IDLE or DONE).
   assign accept     = bus.start && (state_reg != ST_RUN);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_next = state_reg;
      busy_flag  = 1'b0;
      done_flag  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (bus.start) state_next = ST_RUN;
         end
         ST_RUN: begin
            busy_flag = 1'b1;
            if (last_chunk) state_next = ST_DONE;
         end
         ST_DONE: begin
            done_flag  = 1'b1;
            state_next = bus.start ? ST_RUN : ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Operand capture and per-chunk accumulation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg     <= '0;
         b_reg     <= '0;
         carry_reg <= 1'b0;
         idx_reg   <= '0;
         psum_reg  <= '0;
      end else if (accept) begin
         a_reg     <= bus.A;
         b_reg     <= bus.sub ? ~bus.B : bus.B;
         carry_reg <= bus.sub | bus.Cin;
         idx_reg   <= '0;
      end else if (state_reg == ST_RUN) begin
         psum_reg  <= psum_merged;
         carry_reg <= chunk_sum[CHUNK];
         idx_reg   <= idx_reg + IDXW'(1);
      end
   end

   // Publish results only on the edge that finishes the top chunk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_reg    <= '0;
         cout_reg <= 1'b0;
         ovf_reg  <= 1'b0;
      end else if ((state_reg == ST_RUN) && last_chunk) begin
         s_reg    <= psum_merged;
         cout_reg <= chunk_sum[CHUNK];
         ovf_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                     (psum_merged[WIDTH-1] != a_reg[WIDTH-1]);
      end
   end

   assign bus.busy = busy_flag;
   assign bus.done = done_flag;
   assign bus.S    = s_reg;
   assign bus.Cout = cout_reg;
   assign bus.ovf  = ovf_reg;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Randomised and directed checks of seq_chunk_adder against an arithmetic
// reference model (integer add/subtract with range-based overflow).
module tb_seq_chunk_adder;
   localparam int WIDTH = 16;
   localparam int CHUNK = 4;
   localparam int NCH   = WIDTH / CHUNK;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seq_chunk_adder_if #(.WIDTH(WIDTH)) bus ();

   seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   function automatic void ref_op(input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, input logic sub,
                                  output logic [15:0] s, output logic c, output logic v);
      int ua, ub, sa, sb, total, ideal;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sub) begin
         total = ua - ub + 65536;
         c     = (ua >= ub);
         ideal = sa - sb;
      end else begin
         total = ua + ub + int'(cin);
         c     = (total >= 65536);
         ideal = sa + sb + int'(cin);
      end
      s = 16'(total % 65536);
      v = (ideal > 32767) || (ideal < -32768);
   endfunction

   task automatic wait_done(output int n, output int bc);
      bit seen;
      seen = 0;
      n    = 0;
      bc   = 0;
      for (int i = 1; i <= 20 && !seen; i++) begin
         @(negedge clk);
         if (bus.busy) bc++;
         if (bus.done) begin
            seen = 1;
            n    = i;
         end
      end
      if (!seen) check_val("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input bit disturb);
      logic [15:0] es;
      logic        ec, ev;
      int          n, bc;
      ref_op(a, b, cin, sub, es, ec, ev);
      @(negedge clk);
      bus.start = 1'b1;
      bus.A     = a;
      bus.B     = b;
      bus.Cin   = cin;
      bus.sub   = sub;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.A     = 16'($urandom);
      bus.B     = 16'($urandom);
      bus.Cin   = 1'($urandom);
      bus.sub   = 1'($urandom);
      if (disturb) begin
         fork
            begin
               @(negedge clk);
               @(negedge clk);
               bus.start = 1'b1;
               bus.A     = 16'hAAAA;
               bus.B     = 16'h5555;
               @(negedge clk);
               bus.start = 1'b0;
            end
         join_none
      end
      wait_done(n, bc);
      check_val("latency", n, NCH + 1);
      check_val("busy_cycles", bc, NCH);
      check_val("busy_in_done", bus.busy, 1'b0);
      check_val("S", bus.S, es);
      check_val("Cout", bus.Cout, ec);
      check_val("ovf", bus.ovf, ev);
      $display("op sub=%0d A=%04h B=%04h Cin=%0d -> S=%04h Cout=%0d ovf=%0d (exp %04h %0d %0d)",
               sub, a, b, cin, bus.S, bus.Cout, bus.ovf, es, ec, ev);
      @(negedge clk);
      check_val("done_pulse_width", bus.done, 1'b0);
      check_val("idle_after_done", bus.busy, 1'b0);
      check_val("S_held", bus.S, es);
      if (disturb) begin
         repeat (NCH + 1) begin
            @(negedge clk);
            check_val("no_extra_done", bus.done, 1'b0);
         end
         check_val("S_held_late", bus.S, es);
      end
   endtask

   initial begin
      int n, bc;
      bus.start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      bus.Cin   = 1'b0;
      bus.sub   = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_busy", bus.busy, 1'b0);
      check_val("rst_done", bus.done, 1'b0);
      check_val("rst_S", bus.S, 16'h0000);
      check_val("rst_Cout", bus.Cout, 1'b0);
      check_val("rst_ovf", bus.ovf, 1'b0);
      rst_n = 1'b1;

      // Directed cases
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
      run_op(16'h1234, 16'h0FED, 1'b1, 1'b0, 1'b0);
      run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
      run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
      run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b1);

      // Random cases
      for (int i = 0; i < 40; i++) begin
         run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
      end

      // Back-to-back: start held through DONE
      @(negedge clk);
      bus.start = 1'b1;
      bus.A     = 16'h0001;
      bus.B     = 16'h0001;
      bus.Cin   = 1'b0;
      bus.sub   = 1'b0;
      @(posedge clk);
      #1;
      bus.A = 16'h0010;
      bus.B = 16'h0010;
      wait_done(n, bc);
      check_val("b2b_first_S", bus.S, 16'h0002);
      $display("b2b first S=%04h", bus.S);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(n, bc);
      check_val("b2b_gap", n, NCH + 1);
      check_val("b2b_second_S", bus.S, 16'h0020);
      $display("b2b second S=%04h gap=%0d", bus.S, n);

      // Asynchronous reset in the third RUN cycle
      @(negedge clk);
      bus.start = 1'b1;
      bus.A     = 16'h0003;
      bus.B     = 16'h0004;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("async_rst_busy", bus.busy, 1'b0);
      check_val("async_rst_done", bus.done, 1'b0);
      check_val("async_rst_S", bus.S, 16'h0000);
      check_val("async_rst_Cout", bus.Cout, 1'b0);
      check_val("async_rst_ovf", bus.ovf, 1'b0);
      $display("mid-op reset applied S=%04h busy=%0d", bus.S, bus.busy);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (NCH + 3) begin
         @(negedge clk);
         check_val("no_done_after_rst", bus.done, 1'b0);
      end
      run_op(16'h1234, 16'h0FED, 1'b1, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
